// File: rtl/digit_scan_ctrl_if.sv
// rtl/digit_scan_ctrl_if.sv - conversion request, display control and scan output bundle for digit_scan_ctrl
interface digit_scan_ctrl_if #(
  parameter int DIGITS = 8,
  parameter int VAL_W  = 27
);
  localparam int LIGHT_W = ($clog2(DIGITS) > 1) ? $clog2(DIGITS) : 1;

  logic [VAL_W-1:0]   value;
  logic               load;
  logic               busy;
  logic               blank_lz;
  logic [DIGITS-1:0]  dot_mask;
  logic [LIGHT_W-1:0] light;
  logic [3:0]         num;
  logic               dot;
  logic               ovf;

  modport master (
    output value, load, blank_lz, dot_mask,
    input  busy, light, num, dot, ovf
  );

  modport slave (
    input  value, load, blank_lz, dot_mask,
    output busy, light, num, dot, ovf
  );
endinterface

// File: rtl/digit_scan_ctrl.sv
// rtl/digit_scan_ctrl.sv - serial binary-to-BCD converter with double-buffered digit scan; optional DIGIT_BLINK_EN adds blink_mask
module digit_scan_ctrl #(
  parameter int DIGITS    = 8,
  parameter int VAL_W     = 27,
  parameter int SCAN_DIV  = 50000,
  parameter int BLINK_DIV = 25000000
) (
  input  logic              clk,
  input  logic              rst,
`ifdef DIGIT_BLINK_EN
  input  logic [DIGITS-1:0] blink_mask,
`endif
  digit_scan_ctrl_if.slave  bus
);
  localparam int LIGHT_W = ($clog2(DIGITS) > 1) ? $clog2(DIGITS) : 1;
  localparam int BCD_W   = DIGITS * 4;
  localparam int CNT_W   = $clog2(VAL_W + 1);
  localparam int SCAN_W  = ($clog2(SCAN_DIV) > 1) ? $clog2(SCAN_DIV) : 1;

  localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(VAL_W - 1);
  localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [LIGHT_W-1:0] LIGHT_LAST = LIGHT_W'(DIGITS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_COMMIT
  } state_t;

  state_t             state;
  logic               busy_q;
  logic [VAL_W-1:0]   sr;
  logic [BCD_W-1:0]   bcd;
  logic [BCD_W-1:0]   bcd_adj;
  logic               ovf_s;
  logic [CNT_W-1:0]   bit_cnt;
  logic [BCD_W-1:0]   disp;
  logic               ovf_q;

  logic [SCAN_W-1:0]  pcnt;
  logic [LIGHT_W-1:0] light_q;
  logic [LIGHT_W-1:0] light_nxt;
  logic [3:0]         num_q;
  logic [3:0]         code_nxt;
  logic               dot_q;
  logic               dot_nxt;
  logic [3:0]         sel_digit;
  logic               sel_lz;
  logic               sel_blink;
  logic               lead_zero;

`ifdef DIGIT_BLINK_EN
  localparam int BLINK_W = ($clog2(BLINK_DIV) > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

  logic [BLINK_W-1:0] bcnt;
  logic               blink_on;

  // Blink phase: starts "on", toggles every BLINK_DIV cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      bcnt     <= '0;
      blink_on <= 1'b1;
    end else if (bcnt == BLINK_LAST) begin
      bcnt     <= '0;
      blink_on <= ~blink_on;
    end else begin
      bcnt <= bcnt + 1'b1;
    end
  end
`endif

  // Shift-add-3 correction: any nibble >= 5 would carry past 9 after doubling
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd[i*4 +: 4] >= 4'd5) begin
        bcd_adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
      end
    end
  end

  // Conversion FSM: capture, VAL_W shift cycles, then commit to the display buffer
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      busy_q  <= 1'b0;
      sr      <= '0;
      bcd     <= '0;
      ovf_s   <= 1'b0;
      bit_cnt <= '0;
      disp    <= '0;
      ovf_q   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.load) begin
            sr      <= bus.value;
            bcd     <= '0;
            ovf_s   <= 1'b0;
            bit_cnt <= '0;
            busy_q  <= 1'b1;
            state   <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          {bcd, sr} <= {bcd_adj[BCD_W-2:0], sr, 1'b0};
          // A set bit leaving the top nibble means the value needs more digits
          if (bcd_adj[BCD_W-1]) begin
            ovf_s <= 1'b1;
          end
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt == CNT_LAST) begin
            state <= S_COMMIT;
          end
        end
        S_COMMIT: begin
          disp   <= bcd;
          ovf_q  <= ovf_s;
          busy_q <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Next scan position and its digit code, from the committed buffer and live masks
  always_comb begin
    light_nxt = light_q;
    if (pcnt == SCAN_LAST) begin
      light_nxt = (light_q == LIGHT_LAST) ? '0 : light_q + 1'b1;
    end
    sel_digit = '0;
    sel_lz    = 1'b0;
    sel_blink = 1'b0;
    dot_nxt   = 1'b0;
    lead_zero = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      lead_zero = lead_zero & (disp[(DIGITS-1-i)*4 +: 4] == 4'd0);
      if (light_nxt == LIGHT_W'(i)) begin
        sel_digit = disp[(DIGITS-1-i)*4 +: 4];
        sel_lz    = lead_zero && (i != DIGITS - 1);
        dot_nxt   = bus.dot_mask[i];
`ifdef DIGIT_BLINK_EN
        sel_blink = blink_mask[i] && !blink_on;
`endif
      end
    end
    if (ovf_q) begin
      code_nxt = 4'd11;
    end else if (sel_blink) begin
      code_nxt = 4'd12;
    end else if (bus.blank_lz && sel_lz) begin
      code_nxt = 4'd12;
    end else begin
      code_nxt = sel_digit;
    end
  end

  // Scan prescaler and registered light/num/dot, updated together
  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt    <= '0;
      light_q <= '0;
      num_q   <= '0;
      dot_q   <= 1'b0;
    end else begin
      pcnt    <= (pcnt == SCAN_LAST) ? '0 : pcnt + 1'b1;
      light_q <= light_nxt;
      num_q   <= code_nxt;
      dot_q   <= dot_nxt;
    end
  end

  assign bus.busy  = busy_q;
  assign bus.light = light_q;
  assign bus.num   = num_q;
  assign bus.dot   = dot_q;
  assign bus.ovf   = ovf_q;
endmodule

// File: tb/tb_digit_scan_ctrl.sv
// tb/tb_digit_scan_ctrl.sv - randomized model-checked bench for digit_scan_ctrl
module tb_digit_scan_ctrl;
  localparam int D  = 4;
  localparam int VW = 14;
  localparam int SD = 4;
  localparam int BD = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  digit_scan_ctrl_if #(.DIGITS(D), .VAL_W(VW)) bus ();
`ifdef DIGIT_BLINK_EN
  logic [D-1:0] blink_mask = '0;
`endif

  digit_scan_ctrl #(
    .DIGITS(D), .VAL_W(VW), .SCAN_DIV(SD), .BLINK_DIV(BD)
  ) dut (
    .clk(clk),
    .rst(rst),
`ifdef DIGIT_BLINK_EN
    .blink_mask(blink_mask),
`endif
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  int n = 0;
  bit armed = 1'b0;
  int cur_val = 0;
  bit cur_ovf = 1'b0;
  bit pending = 1'b0;
  int pend_val = 0;
  int commit_edge = 0;
  int exp_light = 0, exp_num = 0, exp_dot = 0, exp_busy = 0, exp_ovf = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, want, $time);
    end
  endtask

  function automatic int p10(input int e);
    int r = 1;
    repeat (e) r = r * 10;
    return r;
  endfunction

  // Reference: scan position from edge count, digits from decimal arithmetic
  task automatic model_step();
    int lt;
`ifdef DIGIT_BLINK_EN
    bit ph;
`endif
    if (rst) begin
      n = 0; armed = 1'b1; cur_val = 0; cur_ovf = 1'b0; pending = 1'b0;
      exp_light = 0; exp_num = 0; exp_dot = 0; exp_busy = 0; exp_ovf = 0;
      return;
    end
    if (!armed) return;
    n++;
    lt = (n / SD) % D;
    exp_light = lt;
    exp_dot = bus.dot_mask[lt];
`ifdef DIGIT_BLINK_EN
    ph = (((n - 1) / BD) % 2) == 0;
`endif
    if (cur_ovf) exp_num = 11;
`ifdef DIGIT_BLINK_EN
    else if (blink_mask[lt] && !ph) exp_num = 12;
`endif
    else if (bus.blank_lz && lt < D - 1 && cur_val < p10(D - 1 - lt)) exp_num = 12;
    else exp_num = (cur_val / p10(D - 1 - lt)) % 10;
    if (pending && n == commit_edge) begin
      pending = 1'b0;
      cur_ovf = pend_val >= p10(D);
      cur_val = pend_val % p10(D);
    end else if (!pending && bus.load) begin
      pending = 1'b1;
      pend_val = int'(bus.value);
      commit_edge = n + VW + 1;
    end
    exp_busy = pending;
    exp_ovf = cur_ovf;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (armed) begin
      chk("light", bus.light, exp_light);
      chk("num", bus.num, exp_num);
      chk("dot", bus.dot, exp_dot);
      chk("busy", bus.busy, exp_busy);
      chk("ovf", bus.ovf, exp_ovf);
    end
  end

  task automatic do_load(input int v, output int bcnt);
    bus.value = VW'(v);
    bus.load = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
    bcnt = 0;
    while (bus.busy === 1'b1 && bcnt < 60) begin
      bcnt++;
      @(negedge clk);
    end
  endtask

  task automatic expect_digits(input int d0, input int d1, input int d2, input int d3, input string tag);
    int want[4];
    int g;
    want = '{d0, d1, d2, d3};
    for (int p = 0; p < D; p++) begin
      g = 0;
      @(negedge clk);
      while (bus.light != p && g < 3 * SD * D) begin
        @(negedge clk);
        g++;
      end
      if (bus.light != p) chk({tag, "_light"}, bus.light, p);
      else chk({tag, "_num"}, bus.num, want[p]);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int c, v, g;
    bus.value = '0; bus.load = 1'b0; bus.blank_lz = 1'b0; bus.dot_mask = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_light", bus.light, 0);
    chk("rst_num", bus.num, 0);
    chk("rst_dot", bus.dot, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_ovf", bus.ovf, 0);
    rst = 1'b0;
    for (int q = 1; q <= 4; q++) begin
      repeat (SD) @(negedge clk);
      chk("scan_step", bus.light, q % D);
    end

    do_load(1234, c);
    chk("busy_len", c, 15);
    expect_digits(1, 2, 3, 4, "basic");

    bus.blank_lz = 1'b1;
    do_load(7, c);
    expect_digits(12, 12, 12, 7, "lz7");
    do_load(0, c);
    expect_digits(12, 12, 12, 0, "lz0");
    do_load(1005, c);
    expect_digits(1, 0, 0, 5, "lz1005");
    bus.blank_lz = 1'b0;

    do_load(10000, c);
    chk("ovf_set", bus.ovf, 1);
    expect_digits(11, 11, 11, 11, "ovf");
    do_load(9999, c);
    chk("ovf_clr", bus.ovf, 0);
    expect_digits(9, 9, 9, 9, "max");

    bus.value = VW'(1111); bus.load = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
    repeat (2) @(negedge clk);
    bus.value = VW'(2222); bus.load = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
    g = 0;
    while (bus.busy === 1'b1 && g < 60) begin @(negedge clk); g++; end
    expect_digits(1, 1, 1, 1, "ignored");

    bus.value = VW'(3333); bus.load = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", bus.busy, 0);
    expect_digits(0, 0, 0, 0, "abort");

    bus.dot_mask = 4'b0100;
    for (int p = 0; p < D; p++) begin
      g = 0;
      @(negedge clk);
      while (bus.light != p && g < 3 * SD * D) begin @(negedge clk); g++; end
      chk("dot_pos", bus.dot, (p == 2) ? 1 : 0);
    end

`ifdef DIGIT_BLINK_EN
    do_load(4321, c);
    blink_mask = 4'b0001;
    repeat (6 * SD * D) @(negedge clk);
    blink_mask = '0;
`endif

    for (int it = 0; it < 40; it++) begin
      bus.blank_lz = 1'($urandom_range(0, 1));
      bus.dot_mask = 4'($urandom);
`ifdef DIGIT_BLINK_EN
      blink_mask = 4'($urandom);
`endif
      case ($urandom_range(0, 3))
        0: v = $urandom_range(0, 99);
        1: v = $urandom_range(0, 9999);
        2: v = $urandom_range(10000, 16383);
        default: v = $urandom_range(0, 16383);
      endcase
      bus.value = VW'(v);
      bus.load = 1'b1;
      @(negedge clk);
      bus.load = 1'b0;
      if ($urandom_range(0, 7) == 0) begin
        repeat ($urandom_range(1, 14)) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end else begin
        if ($urandom_range(0, 1) == 1) begin
          repeat ($urandom_range(1, 16)) @(negedge clk);
          bus.value = VW'($urandom_range(0, 16383));
          bus.load = 1'b1;
          @(negedge clk);
          bus.load = 1'b0;
        end
        g = 0;
        while (bus.busy === 1'b1 && g < 60) begin @(negedge clk); g++; end
      end
      repeat ($urandom_range(0, 24)) @(negedge clk);
    end

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
